// File: rtl/ltc2320_emulator.sv
// Responder-side emulation of the 8-lane LTC2320 serial ADC interface for HIL builds.
// CNV/SCK are oversampled on clk_100mhz; samples are shifted out MSB-first with an echoed clock.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for CNV rise, SDO driven low
// CONVERT  | busy time, counting CONV_CYCLES before data is presented
// READY    | MSBs on SDO, waiting for the first full SCK pulse
// SHIFT    | shifting one bit per SCK fall
// DONE     | frame complete, SDO low, extra SCK edges ignored
module ltc2320_emulator #(
    parameter int SYNC_STAGES = 2,
    parameter int CONV_CYCLES = 45,
    parameter int WORD_BITS   = 16
) (
    input  logic                     clk_100mhz,
    input  logic                     reset_100mhz,
    input  logic                     adc_cnv_n,
    input  logic                     adc_sck,
    output logic [7:0]               adc_sdo,
    output logic                     adc_clkout,
    input  logic [8*WORD_BITS-1:0]   sample_data,
    output logic                     busy,
    output logic [15:0]              frame_count,
    output logic                     err_sck_during_conv,
    output logic                     err_cnv_during_read,
    input  logic                     err_clear
);

    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W  = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_READY,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cnv_sync, sck_sync;
    logic                   cnv_lvl, sck_lvl, cnv_hist, sck_hist;
    logic                   cnv_rise, sck_rise, sck_fall;

    logic [WORD_BITS-1:0]   shreg [8];
    logic [7:0]             msb;
    logic [CONV_W-1:0]      conv_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [15:0]            frame_cnt;
    logic                   rise_seen, rise_seen_nxt;

    logic load, shift, conv_clr, bit_ld1, bit_inc, frame_inc, set_sck_err, set_cnv_err;

    // Synchronizers keep sampling through reset so the history FFs can load a settled level.
    always_ff @(posedge clk_100mhz) begin
        cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], adc_cnv_n};
        sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
    end

    assign cnv_lvl  = cnv_sync[SYNC_STAGES-1];
    assign sck_lvl  = sck_sync[SYNC_STAGES-1];
    assign cnv_rise = cnv_lvl & ~cnv_hist;
    assign sck_rise = sck_lvl & ~sck_hist;
    assign sck_fall = ~sck_lvl & sck_hist;

    always_ff @(posedge clk_100mhz) begin
        if (reset_100mhz) begin
            cnv_hist   <= cnv_lvl;
            sck_hist   <= sck_lvl;
            adc_clkout <= 1'b0;
        end else begin
            cnv_hist   <= cnv_lvl;
            sck_hist   <= sck_lvl;
            adc_clkout <= sck_lvl;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset_100mhz) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            msb[i] = shreg[i][WORD_BITS-1];
        end
    end

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        shift         = 1'b0;
        conv_clr      = 1'b0;
        bit_ld1       = 1'b0;
        bit_inc       = 1'b0;
        frame_inc     = 1'b0;
        set_sck_err   = 1'b0;
        set_cnv_err   = 1'b0;
        rise_seen_nxt = rise_seen;
        busy          = 1'b0;
        adc_sdo       = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (cnv_rise) begin
                    load      = 1'b1;
                    conv_clr  = 1'b1;
                    state_nxt = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy          = 1'b1;
                rise_seen_nxt = 1'b0;
                set_sck_err   = sck_rise;
                if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                adc_sdo = msb;
                if (cnv_rise) begin
                    load      = 1'b1;
                    conv_clr  = 1'b1;
                    state_nxt = S_CONVERT;
                end else begin
                    if (sck_rise) begin
                        rise_seen_nxt = 1'b1;
                    end
                    if (sck_fall && rise_seen) begin
                        shift     = 1'b1;
                        bit_ld1   = 1'b1;
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                adc_sdo = msb;
                if (cnv_rise) begin
                    set_cnv_err = 1'b1;
                    load        = 1'b1;
                    conv_clr    = 1'b1;
                    state_nxt   = S_CONVERT;
                end else if (sck_fall) begin
                    shift = 1'b1;
                    if (bit_cnt == BIT_W'(WORD_BITS - 1)) begin
                        frame_inc = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset_100mhz) begin
            for (int i = 0; i < 8; i++) begin
                shreg[i] <= '0;
            end
            conv_cnt            <= '0;
            bit_cnt             <= '0;
            frame_cnt           <= '0;
            rise_seen           <= 1'b0;
            err_sck_during_conv <= 1'b0;
            err_cnv_during_read <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load) begin
                    shreg[i] <= sample_data[i*WORD_BITS +: WORD_BITS];
                end else if (shift) begin
                    shreg[i] <= {shreg[i][WORD_BITS-2:0], 1'b0};
                end
            end
            if (conv_clr) begin
                conv_cnt <= '0;
            end else if (state == S_CONVERT) begin
                conv_cnt <= conv_cnt + 1'b1;
            end
            if (bit_ld1) begin
                bit_cnt <= BIT_W'(1);
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            rise_seen <= rise_seen_nxt;
            // A new error event outranks a coincident clear.
            err_sck_during_conv <= (err_sck_during_conv & ~err_clear) | set_sck_err;
            err_cnv_during_read <= (err_cnv_during_read & ~err_clear) | set_cnv_err;
        end
    end

    assign frame_count = frame_cnt;

endmodule

// File: tb/tb_ltc2320_emulator.sv
// Self-checking bench for ltc2320_emulator: a master drives CNV/SCK and a receiver
// captures SDO on adc_clkout rise; words are compared against the latched samples.
module tb_ltc2320_emulator;

    localparam int CONV_CYCLES = 45;

    logic         clk_100mhz   = 1'b0;
    logic         reset_100mhz = 1'b1;
    logic         adc_cnv_n    = 1'b0;
    logic         adc_sck      = 1'b0;
    logic         err_clear    = 1'b0;
    logic [127:0] sample_data  = '0;
    logic [7:0]   adc_sdo;
    logic         adc_clkout;
    logic         busy;
    logic [15:0]  frame_count;
    logic         err_sck_during_conv;
    logic         err_cnv_during_read;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] cap [64];
    int         cap_total = 0;

    logic [15:0] exp_fc      = '0;
    logic        exp_err_sck = 1'b0;
    logic        exp_err_cnv = 1'b0;

    typedef struct {
        logic [127:0] samples;
        int           n_sck;
        bit           conv_sck;
        logic [15:0]  exp_fc;
        bit           exp_err_sck;
    } vec_t;

    vec_t vecs [4];

    ltc2320_emulator dut (
        .clk_100mhz          (clk_100mhz),
        .reset_100mhz        (reset_100mhz),
        .adc_cnv_n           (adc_cnv_n),
        .adc_sck             (adc_sck),
        .adc_sdo             (adc_sdo),
        .adc_clkout          (adc_clkout),
        .sample_data         (sample_data),
        .busy                (busy),
        .frame_count         (frame_count),
        .err_sck_during_conv (err_sck_during_conv),
        .err_cnv_during_read (err_cnv_during_read),
        .err_clear           (err_clear)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Receiver: latch all lanes shortly after each clkout rise.
    always @(posedge adc_clkout) begin
        #1;
        cap[cap_total % 64] = adc_sdo;
        cap_total++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic pulse_cnv();
        adc_cnv_n = 1'b1;
        cycles(4);
        adc_cnv_n = 1'b0;
    endtask

    task automatic start_conv(input logic [127:0] s, input bit conv_sck);
        sample_data = s;
        pulse_cnv();
        if (conv_sck) begin
            cycles(6);
            adc_sck = 1'b1;
            cycles(4);
            chk("busy_during_conv", {31'd0, busy}, 32'd1);
            chk("err_sck_set", {31'd0, err_sck_during_conv}, 32'd1);
            adc_sck = 1'b0;
            cycles(CONV_CYCLES + 8 - 14);
        end else begin
            cycles(CONV_CYCLES + 8 - 4);
        end
    endtask

    task automatic burst(input int n, output int base);
        base = cap_total;
        for (int i = 0; i < n; i++) begin
            adc_sck = 1'b1;
            cycles(4);
            adc_sck = 1'b0;
            cycles(4);
        end
        cycles(8);
    endtask

    task automatic check_frame(input logic [127:0] s, input int n, input int base);
        logic [15:0] word;
        logic [7:0]  extra;
        chk("clkout_count", cap_total - base, n);
        for (int l = 0; l < 8; l++) begin
            word = '0;
            for (int b = 0; b < 16; b++) begin
                word[15-b] = cap[(base + b) % 64][l];
            end
            chk($sformatf("lane%0d_word", l), {16'd0, word}, {16'd0, s[16*l +: 16]});
        end
        extra = '0;
        for (int b = 16; b < n; b++) begin
            extra |= cap[(base + b) % 64];
        end
        chk("extra_bits_zero", {24'd0, extra}, 32'd0);
        chk("sdo_after_frame", {24'd0, adc_sdo}, 32'd0);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [127:0] s, input int n, input bit conv_sck);
        int base;
        start_conv(s, conv_sck);
        burst(n, base);
        check_frame(s, n, base);
        exp_fc      = exp_fc + 16'd1;
        exp_err_sck = exp_err_sck | conv_sck;
        chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
        chk("err_sck", {31'd0, err_sck_during_conv}, {31'd0, exp_err_sck});
        chk("err_cnv", {31'd0, err_cnv_during_read}, {31'd0, exp_err_cnv});
    endtask

    function automatic logic [127:0] rand_samples();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int          base;
        logic [127:0] s;

        vecs[0] = '{{16'h8001, 96'h0, 16'hA5C3}, 16, 1'b0, 16'd1, 1'b0};
        vecs[1] = '{128'h1111_2222_3333_4444_5555_6666_7777_1234, 16, 1'b1, 16'd2, 1'b1};
        vecs[2] = '{{8{16'hFFFF}}, 20, 1'b0, 16'd3, 1'b1};
        vecs[3] = '{128'h0F0F_F0F0_00FF_FF00_8000_0001_7FFE_C35A, 16, 1'b0, 16'd4, 1'b1};

        cycles(5);
        chk("rst_sdo", {24'd0, adc_sdo}, 32'd0);
        chk("rst_clkout", {31'd0, adc_clkout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_errors", {30'd0, err_sck_during_conv, err_cnv_during_read}, 32'd0);
        reset_100mhz = 1'b0;
        cycles(4);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].samples, vecs[v].n_sck, vecs[v].conv_sck);
            chk($sformatf("tbl%0d_fc", v), {16'd0, frame_count}, {16'd0, vecs[v].exp_fc});
            chk($sformatf("tbl%0d_err_sck", v), {31'd0, err_sck_during_conv}, {31'd0, vecs[v].exp_err_sck});
        end

        err_clear = 1'b1;
        cycles(1);
        err_clear = 1'b0;
        cycles(1);
        exp_err_sck = 1'b0;
        chk("err_sck_cleared", {31'd0, err_sck_during_conv}, 32'd0);

        // CNV during readout aborts the frame and flags it.
        start_conv(rand_samples(), 1'b0);
        burst(7, base);
        s = rand_samples();
        sample_data = s;
        pulse_cnv();
        cycles(2);
        exp_err_cnv = 1'b1;
        chk("abort_err_cnv", {31'd0, err_cnv_during_read}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_fc", {16'd0, frame_count}, {16'd0, exp_fc});
        cycles(CONV_CYCLES + 8 - 6);
        burst(16, base);
        check_frame(s, 16, base);
        exp_fc = exp_fc + 16'd1;
        chk("abort_next_fc", {16'd0, frame_count}, {16'd0, exp_fc});

        // frame_count wrap.
        force dut.frame_cnt = 16'hFFFF;
        cycles(1);
        release dut.frame_cnt;
        exp_fc = 16'hFFFF;
        run_frame(rand_samples(), 16, 1'b0);
        chk("fc_wrap", {16'd0, frame_count}, 32'd0);

        for (int r = 0; r < 5; r++) begin
            run_frame(rand_samples(), $urandom_range(16, 20), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of bit 5, with SCK held high through release.
        start_conv({8{16'hFFFF}}, 1'b0);
        for (int i = 0; i < 4; i++) begin
            adc_sck = 1'b1;
            cycles(4);
            adc_sck = 1'b0;
            cycles(4);
        end
        adc_sck = 1'b1;
        cycles(6);
        reset_100mhz = 1'b1;
        cycles(1);
        chk("midrst_sdo", {24'd0, adc_sdo}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_clkout", {31'd0, adc_clkout}, 32'd0);
        chk("midrst_fc", {16'd0, frame_count}, 32'd0);
        cycles(3);
        reset_100mhz = 1'b0;
        exp_fc      = '0;
        exp_err_sck = 1'b0;
        exp_err_cnv = 1'b0;
        cycles(6);
        adc_sck = 1'b0;
        cycles(6);
        burst(3, base);
        chk("postrst_sdo", {24'd0, adc_sdo}, 32'd0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        chk("postrst_fc", {16'd0, frame_count}, 32'd0);
        run_frame(rand_samples(), 16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
